// File: rtl/lampFPU_pkg.sv
// Shared lampFPU definitions: bfloat16 field widths, canonical special encodings,
// the square-root front-end state type and the operand class record.
package lampFPU_pkg;

  localparam int unsigned LAMP_FLOAT_DW      = 16;
  localparam int unsigned LAMP_FLOAT_E_DW    = 8;
  localparam int unsigned LAMP_FLOAT_F_DW    = 7;
  localparam int unsigned LAMP_FLOAT_E_BIAS  = 127;

  localparam logic [LAMP_FLOAT_DW-1:0] QNAN_BF16 = 16'h7FC0;
  localparam logic [LAMP_FLOAT_DW-1:0] PINF_BF16 = 16'h7F80;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    PACK
  } sqrtFeState_t;

  typedef struct packed {
    logic isZero;
    logic isInf;
    logic isNaN;
    logic isNeg;
  } fpClass_t;

endpackage

// File: rtl/lamp_sqrt_frontend_classify.sv
// Combinational bfloat16 unpack/classify shared by the FPU front ends:
// subnormals flush to zero, exp==all-ones splits into inf / NaN on the fraction.
module lamp_fp_classify
  import lampFPU_pkg::*;
(
  input  logic [LAMP_FLOAT_DW-1:0]   op_i,
  output fpClass_t                   class_o,
  output logic [LAMP_FLOAT_F_DW:0]   s_o,
  output logic                       is_exp_odd_o
);

  logic [LAMP_FLOAT_E_DW-1:0] exp_f;
  logic [LAMP_FLOAT_F_DW-1:0] frac_f;

  always_comb begin
    exp_f          = op_i[LAMP_FLOAT_DW-2 -: LAMP_FLOAT_E_DW];
    frac_f         = op_i[LAMP_FLOAT_F_DW-1:0];
    class_o.isZero = (exp_f == '0);
    class_o.isInf  = (exp_f == '1) && (frac_f == '0);
    class_o.isNaN  = (exp_f == '1) && (frac_f != '0);
    class_o.isNeg  = op_i[LAMP_FLOAT_DW-1];
    s_o            = {1'b1, frac_f};
    // The bias is odd, so exp-127 is odd exactly when the biased exponent is even.
    is_exp_odd_o   = ~exp_f[0];
  end

endmodule

// File: rtl/lamp_sqrt_frontend.sv
// Initiator side of the lampFPU iterative sqrt core: classifies the operand, issues
// it with a doSqrt pulse, waits for the core and packs the result with IEEE flags.
module lamp_sqrt_frontend
  import lampFPU_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      doOp_i,
  input  logic                      invSqrt_i,
  input  logic [LAMP_FLOAT_DW-1:0]  op_i,
  output logic                      busy_o,
  output logic                      valid_o,
  output logic [LAMP_FLOAT_DW-1:0]  res_o,
  output logic                      invalid_o,
  output logic                      divByZero_o,
  output logic                      doSqrt_o,
  output logic [7:0]                s_o,
  output logic                      is_exp_odd_o,
  output logic                      invSqrt_o,
  output logic                      special_case_o,
  input  logic                      sqrt_valid_i,
  input  logic [7:0]                sqrt_res_i
);

  sqrtFeState_t state_q, state_d;

  logic [7:0]               s_q, s_d;
  logic                     odd_q, odd_d;
  logic                     inv_q, inv_d;
  logic                     spcl_q, spcl_d;
  logic [7:0]               e_base_q, e_base_d;
  logic [LAMP_FLOAT_DW-1:0] spec_res_q, spec_res_d;
  logic                     spec_nv_q, spec_nv_d;
  logic                     spec_dz_q, spec_dz_d;
  logic [LAMP_FLOAT_DW-1:0] res_q, res_d;
  logic                     valid_q, valid_d;
  logic                     nv_q, nv_d;
  logic                     dz_q, dz_d;

  fpClass_t                 cls;
  logic [7:0]               cls_s;
  logic                     cls_odd;

  logic signed [7:0]        e_unb;
  logic signed [7:0]        e_half;
  logic [7:0]               e_base;
  logic [7:0]               e_pack;
  logic [6:0]               mant;
  logic [LAMP_FLOAT_DW-1:0] spec_res;
  logic                     spec_nv;
  logic                     spec_dz;

  lamp_fp_classify u_classify (
    .op_i         (op_i),
    .class_o      (cls),
    .s_o          (cls_s),
    .is_exp_odd_o (cls_odd)
  );

  // 8-bit signed arithmetic is exact for every finite normal exponent (1..254).
  always_comb begin
    e_unb  = signed'(op_i[14:7] - 8'(LAMP_FLOAT_E_BIAS));
    e_half = e_unb >>> 1;
    e_base = invSqrt_i ? (8'(LAMP_FLOAT_E_BIAS) - e_half)
                       : (8'(LAMP_FLOAT_E_BIAS) + e_half);
  end

  always_comb begin
    spec_res = '0;
    spec_nv  = 1'b0;
    spec_dz  = 1'b0;
    if (cls.isNaN) begin
      spec_res = QNAN_BF16;
    end else if (cls.isNeg && !cls.isZero) begin
      spec_res = QNAN_BF16;
      spec_nv  = 1'b1;
    end else if (cls.isZero) begin
      spec_res = invSqrt_i ? {op_i[15], PINF_BF16[14:0]} : {op_i[15], 15'h0000};
      spec_dz  = invSqrt_i;
    end else if (cls.isInf) begin
      spec_res = invSqrt_i ? '0 : PINF_BF16;
    end
  end

  always_comb begin
    if (sqrt_res_i[7]) begin
      mant   = sqrt_res_i[6:0];
      e_pack = e_base_q;
    end else begin
      mant   = {sqrt_res_i[5:0], 1'b0};
      e_pack = e_base_q - 8'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    odd_d      = odd_q;
    inv_d      = inv_q;
    spcl_d     = spcl_q;
    e_base_d   = e_base_q;
    spec_res_d = spec_res_q;
    spec_nv_d  = spec_nv_q;
    spec_dz_d  = spec_dz_q;
    res_d      = res_q;
    valid_d    = 1'b0;
    nv_d       = 1'b0;
    dz_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (doOp_i) begin
          s_d        = cls_s;
          odd_d      = cls_odd;
          inv_d      = invSqrt_i;
          spcl_d     = cls.isZero | cls.isInf | cls.isNaN | cls.isNeg;
          e_base_d   = e_base;
          spec_res_d = spec_res;
          spec_nv_d  = spec_nv;
          spec_dz_d  = spec_dz;
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Result is packed while entering PACK so valid_o is high throughout PACK.
        if (sqrt_valid_i) begin
          state_d = PACK;
          valid_d = 1'b1;
          if (spcl_q) begin
            res_d = spec_res_q;
            nv_d  = spec_nv_q;
            dz_d  = spec_dz_q;
          end else begin
            res_d = {1'b0, e_pack, mant};
          end
        end
      end
      PACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      s_q        <= '0;
      odd_q      <= 1'b0;
      inv_q      <= 1'b0;
      spcl_q     <= 1'b0;
      e_base_q   <= '0;
      spec_res_q <= '0;
      spec_nv_q  <= 1'b0;
      spec_dz_q  <= 1'b0;
      res_q      <= '0;
      valid_q    <= 1'b0;
      nv_q       <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      odd_q      <= odd_d;
      inv_q      <= inv_d;
      spcl_q     <= spcl_d;
      e_base_q   <= e_base_d;
      spec_res_q <= spec_res_d;
      spec_nv_q  <= spec_nv_d;
      spec_dz_q  <= spec_dz_d;
      res_q      <= res_d;
      valid_q    <= valid_d;
      nv_q       <= nv_d;
      dz_q       <= dz_d;
    end
  end

  always_comb begin
    busy_o         = (state_q == ISSUE) || (state_q == WAIT);
    doSqrt_o       = (state_q == ISSUE);
    valid_o        = valid_q;
    res_o          = res_q;
    invalid_o      = nv_q;
    divByZero_o    = dz_q;
    s_o            = s_q;
    is_exp_odd_o   = odd_q;
    invSqrt_o      = inv_q;
    special_case_o = spcl_q;
  end

endmodule

// File: tb/tb_lamp_sqrt_frontend.sv
// Scoreboard bench for lamp_sqrt_frontend with a behavioural sqrt-core model.
module tb_lamp_sqrt_frontend;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        doOp_i = 1'b0;
  logic        invSqrt_i = 1'b0;
  logic [15:0] op_i = '0;
  logic        busy_o, valid_o, invalid_o, divByZero_o, doSqrt_o;
  logic [15:0] res_o;
  logic [7:0]  s_o;
  logic        is_exp_odd_o, invSqrt_o, special_case_o;
  logic        sqrt_valid_i = 1'b0;
  logic [7:0]  sqrt_res_i = '0;

  lamp_sqrt_frontend dut (
    .clk            (clk),
    .rst            (rst),
    .doOp_i         (doOp_i),
    .invSqrt_i      (invSqrt_i),
    .op_i           (op_i),
    .busy_o         (busy_o),
    .valid_o        (valid_o),
    .res_o          (res_o),
    .invalid_o      (invalid_o),
    .divByZero_o    (divByZero_o),
    .doSqrt_o       (doSqrt_o),
    .s_o            (s_o),
    .is_exp_odd_o   (is_exp_odd_o),
    .invSqrt_o      (invSqrt_o),
    .special_case_o (special_case_o),
    .sqrt_valid_i   (sqrt_valid_i),
    .sqrt_res_i     (sqrt_res_i)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_valid  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic        nv;
    logic        dz;
    int          due;
  } exp_res_t;

  typedef struct {
    logic [7:0] s;
    logic       odd;
    logic       inv;
    logic       spcl;
    int         due;
  } exp_iss_t;

  exp_res_t sb_q[$];
  exp_iss_t iss_q[$];

  logic [7:0] core_val = '0;
  int         core_cnt = 0;
  int         stray_cnt = 0;
  int         stray_seen = 0;

  // Reference: square-root semantics on bfloat16 fields with plain integer arithmetic.
  function automatic void model(input logic [15:0] op, input logic inv, input logic [7:0] core,
                                output logic [15:0] res, output logic nv, output logic dz,
                                output logic spcl, output logic [7:0] s, output logic odd);
    int e, f, ue, h, eo, m;
    logic neg;
    e   = int'(op[14:7]);
    f   = int'(op[6:0]);
    neg = op[15];
    ue  = e - 127;
    nv  = 1'b0;
    dz  = 1'b0;
    s   = {1'b1, op[6:0]};
    odd = (ue % 2) != 0;
    spcl = 1'b1;
    res  = 16'h0000;
    if (e == 255 && f != 0) begin
      res = 16'h7FC0;
    end else if (e == 0) begin
      if (inv) begin
        res = neg ? 16'hFF80 : 16'h7F80;
        dz  = 1'b1;
      end else begin
        res = neg ? 16'h8000 : 16'h0000;
      end
    end else if (neg) begin
      res = 16'h7FC0;
      nv  = 1'b1;
    end else if (e == 255) begin
      res = inv ? 16'h0000 : 16'h7F80;
    end else begin
      spcl = 1'b0;
      h  = (ue >= 0) ? ue / 2 : -((1 - ue) / 2);
      eo = inv ? 127 - h : 127 + h;
      if (core < 8'd128) begin
        m  = (int'(core) * 2) % 128;
        eo = eo - 1;
      end else begin
        m = int'(core) - 128;
      end
      res = {1'b0, 8'(eo), 7'(m)};
    end
  endfunction

  // Core model: answers 1 cycle after doSqrt for special cases, 6 otherwise.
  always @(negedge clk) begin
    exp_iss_t ei;
    sqrt_valid_i = 1'b0;
    if (rst) begin
      core_cnt = 0;
    end else if (doSqrt_o) begin
      checks++;
      if (iss_q.size() == 0) begin
        failures++;
        $display("FAIL issue_unexpected: doSqrt_o pulsed at cycle %0d with nothing issued", cyc);
      end else begin
        ei = iss_q.pop_front();
        if ({s_o, is_exp_odd_o, invSqrt_o, special_case_o, busy_o} !== {ei.s, ei.odd, ei.inv, ei.spcl, 1'b1}
            || cyc != ei.due) begin
          failures++;
          $display("FAIL issue: got s=%h odd=%b inv=%b spcl=%b busy=%b cyc=%0d expected s=%h odd=%b inv=%b spcl=%b busy=1 cyc=%0d",
                   s_o, is_exp_odd_o, invSqrt_o, special_case_o, busy_o, cyc,
                   ei.s, ei.odd, ei.inv, ei.spcl, ei.due);
        end
      end
      core_cnt = special_case_o ? 1 : 6;
    end else if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        sqrt_valid_i = 1'b1;
        sqrt_res_i   = core_val;
      end
    end else if (stray_cnt != stray_seen) begin
      stray_seen   = stray_cnt;
      sqrt_valid_i = 1'b1;
      sqrt_res_i   = 8'hA5;
    end
  end

  // Monitor: pops the scoreboard on every valid_o.
  always @(negedge clk) begin
    exp_res_t er;
    if (!rst) begin
      if (valid_o) begin
        n_valid++;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL result_unexpected: valid_o at cycle %0d res=%h", cyc, res_o);
        end else begin
          er = sb_q.pop_front();
          if ({res_o, invalid_o, divByZero_o} !== {er.res, er.nv, er.dz} || cyc != er.due) begin
            failures++;
            $display("FAIL result: got res=%h nv=%b dz=%b cyc=%0d expected res=%h nv=%b dz=%b cyc=%0d",
                     res_o, invalid_o, divByZero_o, cyc, er.res, er.nv, er.dz, er.due);
          end
        end
      end else if (invalid_o || divByZero_o) begin
        checks++;
        failures++;
        $display("FAIL flags_idle: got nv=%b dz=%b expected 0 0 with valid_o=0", invalid_o, divByZero_o);
      end
    end
  end

  task automatic do_op(input logic [15:0] op, input logic inv, input logic [7:0] core);
    logic [15:0] r;
    logic nv, dz, spcl, odd;
    logic [7:0] s;
    @(posedge clk); #1;
    model(op, inv, core, r, nv, dz, spcl, s, odd);
    core_val = core;
    iss_q.push_back('{s: s, odd: odd, inv: inv, spcl: spcl, due: cyc + 1});
    sb_q.push_back('{res: r, nv: nv, dz: dz, due: cyc + (spcl ? 3 : 8)});
    op_i      = op;
    invSqrt_i = inv;
    doOp_i    = 1'b1;
    @(posedge clk); #1;
    doOp_i = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: got %0d results outstanding expected 0", sb_q.size());
      sb_q.delete();
      iss_q.delete();
    end
    @(posedge clk);
  endtask

  task automatic check_zero(input string name);
    @(negedge clk);
    checks++;
    if ({busy_o, valid_o, res_o, invalid_o, divByZero_o, doSqrt_o, s_o,
         is_exp_odd_o, invSqrt_o, special_case_o} !== '0) begin
      failures++;
      $display("FAIL %s: got busy=%b valid=%b res=%h nv=%b dz=%b do=%b s=%h odd=%b inv=%b spcl=%b expected all 0",
               name, busy_o, valid_o, res_o, invalid_o, divByZero_o, doSqrt_o, s_o,
               is_exp_odd_o, invSqrt_o, special_case_o);
    end
  endtask

  task automatic check_count(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  initial begin
    int v0;
    logic [15:0] op;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    check_zero("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;

    do_op(16'h4080, 1'b0, 8'h80); wait_done();
    do_op(16'h4000, 1'b0, 8'hB5); wait_done();
    do_op(16'h4080, 1'b1, 8'h80); wait_done();
    do_op(16'h4080, 1'b1, 8'h5A); wait_done();
    do_op(16'hBF80, 1'b0, 8'h33); wait_done();
    do_op(16'h0000, 1'b1, 8'h11); wait_done();
    do_op(16'h7F80, 1'b1, 8'h22); wait_done();
    do_op(16'h8000, 1'b0, 8'h44); wait_done();
    do_op(16'h8000, 1'b1, 8'h44); wait_done();
    do_op(16'hFF80, 1'b1, 8'h44); wait_done();
    do_op(16'h7FC1, 1'b0, 8'h44); wait_done();
    do_op(16'h0045, 1'b0, 8'h44); wait_done();

    // Start request during WAIT must be dropped.
    v0 = n_valid;
    do_op(16'h4080, 1'b0, 8'h80);
    repeat (2) @(posedge clk); #1;
    op_i = 16'hBF80; doOp_i = 1'b1;
    @(posedge clk); #1;
    doOp_i = 1'b0;
    wait_done();
    repeat (10) @(posedge clk);
    check_count("busy_doop_ignored", n_valid - v0, 1);

    // Core valid while idle must be dropped.
    v0 = n_valid;
    stray_cnt++;
    repeat (6) @(posedge clk);
    check_count("stray_core_valid", n_valid - v0, 0);

    // Reset in WAIT aborts the operation.
    v0 = n_valid;
    do_op(16'h4000, 1'b0, 8'hB5);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    sb_q.delete();
    iss_q.delete();
    check_zero("reset_in_wait");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    check_count("reset_no_valid", n_valid - v0, 0);
    do_op(16'h4000, 1'b0, 8'hB5); wait_done();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(9, 0) < 7)
        op = {1'b0, 8'($urandom_range(254, 1)), 7'($urandom)};
      else
        op = 16'($urandom);
      do_op(op, 1'($urandom), 8'($urandom));
      wait_done();
    end

    repeat (4) @(posedge clk);
    check_count("scoreboard_drained", sb_q.size() + iss_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

endmodule
